// File: rtl/spi_slave_if.sv
// Host/SPI-pin bundle for spi_slave: slave modport faces the block, master modport faces the pins and host.
// Combinational wires only; no latency and no backpressure inside the interface.
interface spi_slave_if;
   logic       s_clk;
   logic       s_cs;
   logic       s_mosi;
   logic       s_miso;
   logic [7:0] tx_data;
   logic       tx_we;
   logic       tx_full;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       irq;
   logic       irq_clr;

   modport slave (
      input  s_clk, s_cs, s_mosi, tx_data, tx_we, irq_clr,
      output s_miso, tx_full, rx_data, rx_valid, irq
   );

   modport master (
      output s_clk, s_cs, s_mosi, tx_data, tx_we, irq_clr,
      input  s_miso, tx_full, rx_data, rx_valid, irq
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave with 1-byte TX buffer; rx_valid SYNC_STAGES+1 clks after the 8th s_clk rise, tx_we ignored while tx_full.
// Optional receive interrupt flag enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic       clk,
   input  logic       nreset,
   spi_slave_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, settle_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   armed_q, armed_d;
   logic                   sclk_s, cs_s, mosi_s, settled;
   logic                   sclk_rise, sclk_fall, cs_fall;
   logic [7:0]             tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic [7:0]             buf_q, buf_d, rx_data_q, rx_data_d;
   logic                   tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   load, miso;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign settled   = settle_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = cs_prev_q & ~cs_s;
   // A frame may only start after s_cs has been seen high on real (non-preset) samples since reset.
   assign armed_d   = armed_q | (settled & cs_s);

   always_ff @(posedge clk) begin
      if (!nreset) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         settle_q    <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         armed_q     <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.s_clk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.s_cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.s_mosi};
         settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         armed_q     <= armed_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (cs_fall && armed_q) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: if (cs_s) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Reload after the 8th bit happens on the fall that follows the counter wrapping to 0.
   always_comb begin
      miso = 1'b1;
      load = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            miso = tx_sh_q[7];
            load = 1'b1;
         end
         ST_SHIFT: begin
            miso = tx_sh_q[7];
            load = sclk_fall && !cs_s && (bit_cnt_q == 3'd0);
         end
         default: ;
      endcase
   end

   always_comb begin
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      buf_d      = buf_q;
      tx_full_d  = tx_full_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      bit_cnt_d  = bit_cnt_q;
      if (load) begin
         tx_sh_d   = tx_full_q ? buf_q : IDLE_BYTE;
         tx_full_d = 1'b0;
      end else if (state_q == ST_SHIFT && !cs_s && sclk_fall) begin
         tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end
      if (bus.tx_we && !tx_full_q) begin
         buf_d     = bus.tx_data;
         tx_full_d = 1'b1;
      end
      if (state_q == ST_SHIFT && !cs_s && sclk_rise) begin
         rx_sh_d   = {rx_sh_q[6:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_sh_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
         end
      end
      if (state_q != ST_SHIFT) bit_cnt_d = 3'd0;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         tx_sh_q    <= IDLE_BYTE;
         rx_sh_q    <= 8'h00;
         buf_q      <= 8'h00;
         tx_full_q  <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         bit_cnt_q  <= 3'd0;
      end else begin
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         buf_q      <= buf_d;
         tx_full_q  <= tx_full_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign bus.s_miso   = miso;
   assign bus.tx_full  = tx_full_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_IRQ_EN
   logic irq_q, irq_d;

   // Set has priority so a clear racing a new byte never loses the interrupt.
   always_comb begin
      irq_d = irq_q;
      if (bus.irq_clr) irq_d = 1'b0;
      if (rx_valid_q)  irq_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!nreset) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end

   assign bus.irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = bus.irq_clr;
   assign bus.irq        = 1'b0;
`endif
endmodule
